electr_config_deserializer: RTL and testbench

Receive-side counterpart of the electrode-configuration serializer: samples a serial MSB-first stream qualified by a frame-enable, rebuilds the N_ELECTRODES-bit configuration word and presents it in parallel with a one-cycle valid strobe. Sits at the electrode-array / FPGA boundary that consumes the serial link. Checks frame length and flags short and long frames.

---
 rtl/electr_config_deserializer.sv | 125 ++++++++++++
 tb/tb_electr_config_deserializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/electr_config_deserializer.sv
// ---------------------------------------------------------------------------
// electr_config_deserializer
//
// Receives the electrode-configuration word as a serial MSB-first stream
// qualified by enable_config. The word is rebuilt in a shift register and
// presented on config_out with a one-cycle config_valid strobe. Frames that
// are too short or too long are dropped and flagged on frame_err and
// err_sticky.
//
// Ports
//   CLK            in   system clock, rising edge
//   RST_N          in   asynchronous active-low reset
//   serial_in      in   serial data, MSB first
//   enable_config  in   frame enable, one bit per cycle while high
//   err_clr        in   synchronous clear of err_sticky
//   config_out     out  last correctly received configuration word
//   config_valid   out  one-cycle pulse when config_out updates
//   frame_err      out  one-cycle pulse on a short or long frame
//   err_sticky     out  latched frame error, cleared by err_clr
//   rx_busy        out  high while a frame is being received
//   bit_count      out  bits captured in the current / most recent frame
//
// State table
//   S_IDLE     | waiting for enable_config to start a frame
//   S_RX_SHIFT | frame in progress, shifting bits in
// ---------------------------------------------------------------------------
module electr_config_deserializer #(
    parameter int N_ELECTRODES = 129,
    parameter int CNT_W        = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    serial_in,
    input  logic                    enable_config,
    input  logic                    err_clr,
    output logic [N_ELECTRODES-1:0] config_out,
    output logic                    config_valid,
    output logic                    frame_err,
    output logic                    err_sticky,
    output logic                    rx_busy,
    output logic [CNT_W-1:0]        bit_count
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_RX_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] C_N     = CNT_W'(N_ELECTRODES);
    localparam logic [CNT_W-1:0] C_N_P1  = CNT_W'(N_ELECTRODES + 1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [0:0]              r_state;
    logic [N_ELECTRODES-1:0] r_shift;
    logic [N_ELECTRODES-1:0] r_config;
    logic                    r_config_valid;
    logic                    r_frame_err;
    logic                    r_err_sticky;
    logic [CNT_W-1:0]        r_bit_count;

    logic [N_ELECTRODES-1:0] w_shift_next;

    assign w_shift_next = {r_shift[N_ELECTRODES-2:0], serial_in};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= S_IDLE;
            r_shift        <= '0;
            r_config       <= '0;
            r_config_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_bit_count    <= '0;
        end else begin
            r_config_valid <= 1'b0;
            r_frame_err    <= 1'b0;

            // Clear first so a frame error later in this block takes priority.
            if (err_clr) begin
                r_err_sticky <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable_config) begin
                        r_shift     <= w_shift_next;
                        r_bit_count <= C_ONE;
                        r_state     <= S_RX_SHIFT;
                    end
                end

                S_RX_SHIFT: begin
                    if (enable_config) begin
                        if (r_bit_count < C_N) begin
                            r_shift     <= w_shift_next;
                            r_bit_count <= r_bit_count + C_ONE;
                        end else if (r_bit_count < C_N_P1) begin
                            // Long frame: keep the first N bits, count saturates at N+1.
                            r_bit_count <= r_bit_count + C_ONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        if (r_bit_count == C_N) begin
                            r_config       <= r_shift;
                            r_config_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                            r_err_sticky <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign config_out   = r_config;
    assign config_valid = r_config_valid;
    assign frame_err    = r_frame_err;
    assign err_sticky   = r_err_sticky;
    assign rx_busy      = (r_state == S_RX_SHIFT);
    assign bit_count    = r_bit_count;

endmodule

// File: tb/tb_electr_config_deserializer.sv
module tb_electr_config_deserializer;

    localparam int N     = 129;
    localparam int CNT_W = 8;

    logic             CLK;
    logic             RST_N;
    logic             serial_in;
    logic             enable_config;
    logic             err_clr;
    logic [N-1:0]     config_out;
    logic             config_valid;
    logic             frame_err;
    logic             err_sticky;
    logic             rx_busy;
    logic [CNT_W-1:0] bit_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_both   = 0;

    electr_config_deserializer #(
        .N_ELECTRODES (N),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .serial_in     (serial_in),
        .enable_config (enable_config),
        .err_clr       (err_clr),
        .config_out    (config_out),
        .config_valid  (config_valid),
        .frame_err     (frame_err),
        .err_sticky    (err_sticky),
        .rx_busy       (rx_busy),
        .bit_count     (bit_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (config_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1) n_ferr++;
        if (config_valid === 1'b1 && frame_err === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. Drives nbits with enable high, then drops enable
    // and returns at the falling edge before the end-of-frame rising edge.
    task automatic send_frame(input logic [N-1:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            enable_config = 1'b1;
            serial_in     = (i < N) ? data[N-1-i] : 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        enable_config = 1'b0;
        serial_in     = 1'($urandom_range(0, 1));
    endtask

    localparam logic [N-1:0] V_T2   = {1'b1, 127'd0, 1'b1};
    localparam logic [N-1:0] V_ONES = {N{1'b1}};
    localparam logic [N-1:0] V_AAAA = {1'b0, {32{4'hA}}};
    localparam logic [N-1:0] V_ALT  = {1'b1, {32{4'h5}}};

    int v0;
    int f0;

    initial begin
        RST_N         = 1'b0;
        serial_in     = 1'b0;
        enable_config = 1'b0;
        err_clr       = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            serial_in = 1'($urandom_range(0, 1));
            chk("reset_idle", {config_out, config_valid, frame_err, err_sticky, rx_busy, bit_count},
                160'd0);
        end

        // 2: nominal frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(V_T2, N);
        chk("t2_busy_before_eof", rx_busy, 1'b1);
        @(negedge CLK);
        chk("t2_valid", config_valid, 1'b1);
        chk("t2_config", config_out, V_T2);
        chk("t2_bit_count", bit_count, 8'd129);
        chk("t2_busy_idle", rx_busy, 1'b0);
        @(negedge CLK);
        chk("t2_valid_one_cycle", config_valid, 1'b0);
        chk("t2_valid_count", n_valid - v0, 1);
        chk("t2_no_frame_err", n_ferr - f0, 0);

        // 3: short frame, then clear sticky
        v0 = n_valid;
        send_frame(V_ONES, 100);
        @(negedge CLK);
        chk("t3_frame_err", frame_err, 1'b1);
        chk("t3_sticky", err_sticky, 1'b1);
        chk("t3_config_kept", config_out, V_T2);
        chk("t3_bit_count", bit_count, 8'd100);
        @(negedge CLK);
        chk("t3_err_one_cycle", frame_err, 1'b0);
        chk("t3_no_valid", n_valid - v0, 0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("t3_sticky_cleared", err_sticky, 1'b0);

        // 4: long frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(V_ONES, 131);
        @(negedge CLK);
        chk("t4_frame_err", frame_err, 1'b1);
        chk("t4_bit_count_sat", bit_count, 8'd130);
        chk("t4_config_kept", config_out, V_T2);
        chk("t4_sticky", err_sticky, 1'b1);
        @(negedge CLK);
        chk("t4_no_valid", n_valid - v0, 0);
        chk("t4_err_count", n_ferr - f0, 1);

        // 5: back-to-back frames with a one-cycle gap
        v0 = n_valid;
        send_frame(V_ONES, N);
        @(negedge CLK);
        chk("t5_valid_a", config_valid, 1'b1);
        chk("t5_config_a", config_out, V_ONES);
        send_frame(V_AAAA, N);
        @(negedge CLK);
        chk("t5_valid_b", config_valid, 1'b1);
        chk("t5_config_b", config_out, V_AAAA);
        @(negedge CLK);
        chk("t5_valid_count", n_valid - v0, 2);

        // 6: reset mid-frame, then a clean frame, then clear/set collision
        for (int i = 0; i < 50; i++) begin
            enable_config = 1'b1;
            serial_in     = V_ALT[N-1-i];
            @(negedge CLK);
        end
        chk("t6_busy_mid", rx_busy, 1'b1);
        enable_config = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("t6_async_reset", {config_out, config_valid, frame_err, err_sticky, rx_busy, bit_count},
            160'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        v0 = n_valid;
        send_frame(V_ALT, N);
        @(negedge CLK);
        chk("t6_valid", config_valid, 1'b1);
        chk("t6_config", config_out, V_ALT);
        send_frame(V_ONES, 10);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("t6_err_pulse", frame_err, 1'b1);
        chk("t6_set_wins", err_sticky, 1'b1);
        chk("t6_config_kept", config_out, V_ALT);
        @(negedge CLK);
        chk("t6_valid_count", n_valid - v0, 1);
        chk("never_both_high", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
